rv_trace_encoder: RTL and testbench

Hardware commit-trace encoder for the pipelined RISC-V core. It captures the per-instruction retirement record (pc, instr, destination write, memory access) on each `update` pulse and buffers records in a small FIFO. It serializes each record into a variable-length little-endian byte stream with a valid/ready handshake, for a UART or debug link. It also keeps retired-instruction, cycle and dropped-record counters so CPI can be measured on silicon.

---
 rtl/rv_trace_encoder_if.sv | 9 +
 rtl/rv_trace_encoder.sv | 226 ++++++++++++++++++++++
 tb/tb_rv_trace_encoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_trace_encoder_if.sv
// Byte-stream link from the trace encoder to a UART or debug transport.
interface rv_trace_encoder_if;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
  modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/rv_trace_encoder.sv
// Commit-trace encoder: buffers retirement records in a FIFO and serializes each
// into a variable-length little-endian byte stream, with CPI/drop counters.
module rv_trace_encoder #(
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned XLEN      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              update_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [4:0]        reg_addr_i,
  input  logic [XLEN-1:0]   reg_data_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              mem_wrt_i,
  input  logic              mem_read_i,
  rv_trace_encoder_if.master tx,
  output logic [31:0]       instr_cnt_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [15:0]       drop_cnt_o,
  output logic              busy_o
);

  localparam int unsigned PtrW         = $clog2(FifoDepth);
  localparam int unsigned CntW         = PtrW + 1;
  localparam logic [6:0]  OpcodeBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StIdle, StHdr, StPc, StInstr, StRd, StMaddr, StMdata
  } state_e;

  typedef struct packed {
    logic            lost;
    logic            c;
    logic            rd;
    logic            ld;
    logic            st;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  rec_t            fifo_q [FifoDepth];
  logic [CntW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic            ra_q, ra_d;
  rec_t            hold_q, hold_d;
  logic            lost_q, lost_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [31:0]     instr_cnt_q, instr_cnt_d;
  logic [31:0]     cycle_cnt_q, cycle_cnt_d;
  logic [15:0]     drop_q, drop_d;
  logic            busy_q, busy_d;

  logic empty, full, push, pop, hs, rec_done;
  rec_t rec_in;

  // Byte presented for a given serializer position.
  function automatic logic [7:0] sel_byte(state_e s, logic [1:0] i, logic ra, rec_t r);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      StHdr:   b = {3'b101, r.lost, r.c, r.rd, r.ld, r.st};
      StPc:    b = r.pc[{i, 3'b000} +: 8];
      StInstr: b = r.instr[{i, 3'b000} +: 8];
      StRd:    b = ra ? {3'b000, r.reg_addr} : r.reg_data[{i, 3'b000} +: 8];
      StMaddr: b = r.mem_addr[{i, 3'b000} +: 8];
      StMdata: b = r.mem_data[{i, 3'b000} +: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Record capture and FIFO status.
  always_comb begin
    rec_in          = '0;
    rec_in.lost     = lost_q;
    rec_in.c        = (instr_i[1:0] != 2'b11);
    rec_in.rd       = (reg_addr_i != 5'd0) && !mem_wrt_i && (instr_i[6:0] != OpcodeBranch);
    rec_in.ld       = mem_read_i && !mem_wrt_i;
    rec_in.st       = mem_wrt_i;
    rec_in.reg_addr = reg_addr_i;
    rec_in.pc       = pc_i;
    rec_in.instr    = instr_i;
    rec_in.reg_data = reg_data_i;
    rec_in.mem_addr = mem_addr_i;
    rec_in.mem_data = mem_data_i;
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
            (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  end

  // Serializer next state; idle is treated as a finished record so both pop the same way.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ra_d     = ra_q;
    hold_d   = hold_q;
    pop      = 1'b0;
    rec_done = 1'b0;
    hs       = tx_valid_q && tx.tx_ready_i;
    case (state_q)
      StIdle: rec_done = 1'b1;
      StHdr: if (hs) begin
        state_d = StPc;
        idx_d   = 2'd0;
      end
      StPc: if (hs) begin
        if (idx_q == 2'd3) begin
          state_d = StInstr;
          idx_d   = 2'd0;
        end else idx_d = idx_q + 2'd1;
      end
      StInstr: if (hs) begin
        if (idx_q == (hold_q.c ? 2'd1 : 2'd3)) begin
          idx_d = 2'd0;
          if (hold_q.rd) begin
            state_d = StRd;
            ra_d    = 1'b1;
          end else if (hold_q.ld || hold_q.st) state_d = StMaddr;
          else rec_done = 1'b1;
        end else idx_d = idx_q + 2'd1;
      end
      StRd: if (hs) begin
        if (ra_q) ra_d = 1'b0;
        else if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (hold_q.ld || hold_q.st) state_d = StMaddr;
          else rec_done = 1'b1;
        end else idx_d = idx_q + 2'd1;
      end
      StMaddr: if (hs) begin
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (hold_q.st) state_d = StMdata;
          else rec_done = 1'b1;
        end else idx_d = idx_q + 2'd1;
      end
      StMdata: if (hs) begin
        if (idx_q == 2'd3) begin
          idx_d    = 2'd0;
          rec_done = 1'b1;
        end else idx_d = idx_q + 2'd1;
      end
      default: state_d = StIdle;
    endcase
    if (rec_done) begin
      if (!empty) begin
        state_d = StHdr;
        pop     = 1'b1;
        hold_d  = fifo_q[rd_ptr_q[PtrW-1:0]];
      end else state_d = StIdle;
    end
    tx_valid_d = (state_d != StIdle);
    tx_data_d  = sel_byte(state_d, idx_d, ra_d, hold_d);
  end

  // Push/drop accounting and counters; a pop frees a slot for a same-cycle push.
  always_comb begin
    push        = update_i && (!full || pop);
    wr_ptr_d    = wr_ptr_q + CntW'(push);
    rd_ptr_d    = rd_ptr_q + CntW'(pop);
    lost_d      = lost_q;
    drop_d      = drop_q;
    if (update_i) begin
      if (push) lost_d = 1'b0;
      else begin
        lost_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
    instr_cnt_d = instr_cnt_q + 32'(update_i);
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    busy_d      = (wr_ptr_d != rd_ptr_d) || (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      ra_q        <= 1'b0;
      hold_q      <= '0;
      lost_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      instr_cnt_q <= 32'd0;
      cycle_cnt_q <= 32'd0;
      drop_q      <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      ra_q        <= ra_d;
      hold_q      <= hold_d;
      lost_q      <= lost_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) fifo_q[wr_ptr_q[PtrW-1:0]] <= rec_in;
  end

  assign tx.tx_data_o  = tx_data_q;
  assign tx.tx_valid_o = tx_valid_q;
  assign instr_cnt_o   = instr_cnt_q;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_rv_trace_encoder.sv
// Bench for rv_trace_encoder: directed record table, hand-written corner sequences and
// randomized bursts compared against a byte-stream model of the record format.
module tb_rv_trace_encoder;
  localparam int unsigned Depth    = 8;
  localparam logic [6:0]  OpBranch = 7'b1100011;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  ra;
    logic [31:0] rdat;
    logic [31:0] maddr;
    logic [31:0] mdat;
    logic        mw;
    logic        mr;
  } rec_t;

  typedef struct {
    rec_t       r;
    logic [7:0] hdr;
    int         len;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic [31:0] pc = '0, instr = '0, rdat = '0, maddr = '0, mdat = '0;
  logic [4:0]  ra = '0;
  logic        mw = 1'b0, mr = 1'b0;
  logic [31:0] icnt, ccnt;
  logic [15:0] dcnt;
  logic        busy;

  rv_trace_encoder_if tx ();

  rv_trace_encoder #(.FifoDepth(Depth), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .update_i(upd), .pc_i(pc), .instr_i(instr),
    .reg_addr_i(ra), .reg_data_i(rdat), .mem_addr_i(maddr), .mem_data_i(mdat),
    .mem_wrt_i(mw), .mem_read_i(mr), .tx(tx), .instr_cnt_o(icnt),
    .cycle_cnt_o(ccnt), .drop_cnt_o(dcnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_upd = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         rnd_ready = 1'b0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic void push_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  // Expected bytes of one record, straight from the record-format rules.
  function automatic void expect_rec(input rec_t r, input logic lost);
    logic c, rd, ld, st;
    c  = (r.instr[1:0] != 2'b11);
    rd = (r.ra != 5'd0) && !r.mw && (r.instr[6:0] != OpBranch);
    ld = r.mr && !r.mw;
    st = r.mw;
    exp_q.push_back({3'b101, lost, c, rd, ld, st});
    push_word(r.pc, 4);
    push_word(r.instr, c ? 2 : 4);
    if (rd) begin
      exp_q.push_back({3'b000, r.ra});
      push_word(r.rdat, 4);
    end
    if (ld || st) push_word(r.maddr, 4);
    if (st) push_word(r.mdat, 4);
  endfunction

  function automatic rec_t mk(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] ma, input logic [31:0] md,
                              input logic w, input logic rd_en);
    rec_t r;
    r.pc = p; r.instr = ins; r.ra = a; r.rdat = d;
    r.maddr = ma; r.mdat = md; r.mw = w; r.mr = rd_en;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.pc    = $urandom;
    r.instr = $urandom;
    if ($urandom_range(0, 3) == 0) r.instr[6:0] = OpBranch;
    r.ra    = 5'($urandom);
    if ($urandom_range(0, 7) == 0) r.ra = 5'd0;
    r.rdat  = $urandom;
    r.maddr = $urandom;
    r.mdat  = $urandom;
    r.mw    = 1'($urandom_range(0, 1));
    r.mr    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One clock: observe the handshake mid-cycle, then return just after the edge.
  task automatic tick();
    @(negedge clk);
    if (rst) stall_q = 1'b0;
    else begin
      if (stall_q)
        check("hold", {23'd0, tx.tx_valid_o, tx.tx_data_o}, {23'd0, 1'b1, stall_data});
      if (tx.tx_valid_o && tx.tx_ready_i) got_q.push_back(tx.tx_data_o);
      stall_q    = tx.tx_valid_o && !tx.tx_ready_i;
      stall_data = tx.tx_data_o;
    end
    @(posedge clk);
    #1;
    if (rnd_ready) tx.tx_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic do_update(input rec_t r, input bit keep, input logic lost);
    pc = r.pc; instr = r.instr; ra = r.ra; rdat = r.rdat;
    maddr = r.maddr; mdat = r.mdat; mw = r.mw; mr = r.mr;
    upd = 1'b1;
    if (keep) expect_rec(r, lost);
    if (!rst) n_upd++;
    tick();
    upd = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((busy || tx.tx_valid_o) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({name, "_drain"}, 32'(busy), 32'd0);
  endtask

  task automatic check_stream(input string name);
    logic [7:0] g;
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'h00;
      check($sformatf("%s_b%0d", name, i), 32'(g), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_bytes(input string name, input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 500) begin
      tick();
      cyc++;
    end
    check({name, "_wait"}, 32'(got_q.size()), 32'(n));
  endtask

  initial begin
    vec_t       tbl [7];
    logic [7:0] alu_lit [14];
    rec_t       r;
    int         gaps, cyc, nb;

    alu_lit = '{8'hA4, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0,
                8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h00};
    tbl[0] = '{r: mk(32'h10, 32'h00A00093, 5'd1, 32'hA, 32'h0, 32'h0, 1'b0, 1'b0), hdr: 8'hA4, len: 14};
    tbl[1] = '{r: mk(32'h20, 32'h0000C004, 5'd9, 32'h77, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0), hdr: 8'hA9, len: 15};
    tbl[2] = '{r: mk(32'h30, 32'h00208463, 5'd8, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0), hdr: 8'hA0, len: 9};
    tbl[3] = '{r: mk(32'h40, 32'h00100013, 5'd0, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0), hdr: 8'hA0, len: 9};
    tbl[4] = '{r: mk(32'h50, 32'h0002A283, 5'd5, 32'h12345678, 32'h2000, 32'h0, 1'b0, 1'b1), hdr: 8'hA6, len: 18};
    tbl[5] = '{r: mk(32'h60, 32'h00112023, 5'd3, 32'h1, 32'h3004, 32'hCAFEF00D, 1'b1, 1'b1), hdr: 8'hA1, len: 17};
    tbl[6] = '{r: mk(32'h70, 32'h00000505, 5'd10, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0), hdr: 8'hAC, len: 12};

    // Reset values and cycle counter start.
    tx.tx_ready_i = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(tx.tx_valid_o), 32'd0);
    check("rst_data", 32'(tx.tx_data_o), 32'd0);
    check("rst_icnt", icnt, 32'd0);
    check("rst_ccnt", ccnt, 32'd0);
    check("rst_dcnt", 32'(dcnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("ccnt_5", ccnt, 32'd5);

    // Directed single-record table.
    for (int i = 0; i < 7; i++) begin
      do_update(tbl[i].r, 1'b1, 1'b0);
      check($sformatf("v%0d_lat_n1", i), 32'(tx.tx_valid_o), 32'd0);
      tick();
      check($sformatf("v%0d_lat_n2", i), {23'd0, tx.tx_valid_o, tx.tx_data_o}, {23'd0, 1'b1, tbl[i].hdr});
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_hdr", i), 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'(tbl[i].hdr));
      check($sformatf("v%0d_reclen", i), 32'(got_q.size()), 32'(tbl[i].len));
      if (i == 0)
        for (int j = 0; j < 14; j++)
          check($sformatf("alu_lit%0d", j), 32'(j < got_q.size() ? got_q[j] : 8'h00), 32'(alu_lit[j]));
      check_stream($sformatf("v%0d", i));
    end
    check("tbl_icnt", icnt, 32'(n_upd));

    // Back-to-back records with ready held high leave no idle cycle.
    do_update(tbl[0].r, 1'b1, 1'b0);
    do_update(tbl[4].r, 1'b1, 1'b0);
    do_update(tbl[1].r, 1'b1, 1'b0);
    gaps = 0;
    cyc  = 0;
    while (busy && cyc < 200) begin
      if (!tx.tx_valid_o) gaps++;
      tick();
      cyc++;
    end
    check("thru_gaps", 32'(gaps), 32'd0);
    check("thru_idle", 32'(busy), 32'd0);
    check_stream("thru");

    // Random bursts under random backpressure.
    rnd_ready = 1'b1;
    for (int b = 0; b < 25; b++) begin
      nb = $urandom_range(1, Depth);
      for (int k = 0; k < nb; k++) begin
        do_update(rand_rec(), 1'b1, 1'b0);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain("rnd");
      check_stream($sformatf("rnd%0d", b));
    end
    rnd_ready = 1'b0;
    tx.tx_ready_i = 1'b1;
    check("rnd_dcnt", 32'(dcnt), 32'd0);
    check("rnd_icnt", icnt, 32'(n_upd));

    // Overflow: one record sits in the holding register, Depth in the FIFO, the rest drop.
    tx.tx_ready_i = 1'b0;
    for (int k = 0; k < 10; k++)
      do_update(mk(32'h1000 + 32'(k * 4), 32'h00100093, 5'd1, 32'(k), 32'h0, 32'h0, 1'b0, 1'b0),
                k < Depth + 1, 1'b0);
    check("ovf_dcnt", 32'(dcnt), 32'd1);
    check("ovf_icnt", icnt, 32'(n_upd));
    tx.tx_ready_i = 1'b1;
    wait_bytes("ovf", 13);
    // Update lands in the cycle the full FIFO pops: accepted, carries the lost flag.
    do_update(mk(32'h2000, 32'h00000013, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0), 1'b1, 1'b1);
    check("pushpop_dcnt", 32'(dcnt), 32'd1);
    drain("ovf");
    check_stream("ovf");
    check("ovf_icnt2", icnt, 32'(n_upd));

    // Reset mid-record discards everything; update during reset is ignored.
    do_update(tbl[4].r, 1'b0, 1'b0);
    wait_bytes("mid", 3);
    rst = 1'b1;
    upd = 1'b1;
    tick();
    upd = 1'b0;
    check("mid_valid", 32'(tx.tx_valid_o), 32'd0);
    check("mid_data", 32'(tx.tx_data_o), 32'd0);
    check("mid_icnt", icnt, 32'd0);
    check("mid_ccnt", ccnt, 32'd0);
    check("mid_dcnt", 32'(dcnt), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    n_upd = 0;
    got_q.delete();
    exp_q.delete();
    repeat (4) tick();
    check("mid_no_trail", 32'(got_q.size()), 32'd0);
    check("mid_icnt_idle", icnt, 32'd0);
    r = tbl[2].r;
    do_update(r, 1'b1, 1'b0);
    drain("post_rst");
    check_stream("post_rst");
    check("post_rst_icnt", icnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
